// File: rtl/clken_gen.sv
// Programmable clock-enable generator: NCH independent divide-by-D[i] channels
// sharing one master clock, with glitch-free divisor updates, pause/step and sync.
module clken_gen #(
  parameter int NCH      = 2,
  parameter int DIV_W    = 5,
  parameter int DIV_INIT = 14,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk14,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [NCH-1:0]   ch_en,
  input  logic             pause,
  input  logic             step,
  input  logic             sync,
  output logic [NCH-1:0]   clken,
  output logic [NCH-1:0]   div_pending
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] div_q  [NCH];
  logic [DIV_W-1:0] pend_q [NCH];
  logic [DIV_W-1:0] cnt_q  [NCH];
  logic [DIV_W-1:0] pend_next [NCH];
  logic [NCH-1:0]   pending_q, clken_q;
  logic [NCH-1:0]   wr_hit, wrap, at_zero;

  // Out-of-range channel numbers match no channel, so such writes fall away.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_hit  = '0;
    wrap    = '0;
    at_zero = '0;
    for (int i = 0; i < NCH; i++) begin
      pend_next[i] = pend_q[i];
      wr_hit[i]    = wr_en && (wr_ch == CH_W'(i));
      if (wr_hit[i]) pend_next[i] = wr_div;
      wrap[i]      = (div_q[i] <= ONE) || (cnt_q[i] == div_q[i] - ONE);
      at_zero[i]   = (cnt_q[i] == '0);
    end
  end

  always_ff @(posedge clk14) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: these per-channel arrays are small flop banks, not a RAM, so they
      // take the reset like any other register.
      for (int i = 0; i < NCH; i++) begin
        div_q[i]  <= DIV_RST;
        pend_q[i] <= DIV_RST;
        cnt_q[i]  <= '0;
      end
      pending_q <= '0;
      clken_q   <= '0;
    end else if (sync) begin
      // Realign: every channel restarts its period with the newest divisor.
      for (int i = 0; i < NCH; i++) begin
        div_q[i]  <= pend_next[i];
        pend_q[i] <= pend_next[i];
        cnt_q[i]  <= '0;
      end
      pending_q <= '0;
      clken_q   <= '0;
    end else if (pause) begin
      for (int i = 0; i < NCH; i++) begin
        pend_q[i] <= pend_next[i];
      end
      pending_q <= pending_q | wr_hit;
      clken_q   <= step ? ch_en : '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pend_q[i] <= pend_next[i];
        if (wrap[i]) begin
          // Divisor changes only at a period boundary, so no period is ever cut.
          cnt_q[i]     <= '0;
          div_q[i]     <= pend_next[i];
          pending_q[i] <= 1'b0;
        end else begin
          cnt_q[i]     <= cnt_q[i] + ONE;
          pending_q[i] <= pending_q[i] | wr_hit[i];
        end
      end
      clken_q <= ch_en & at_zero;
    end
  end

  assign clken       = clken_q;
  assign div_pending = pending_q;

endmodule

// File: tb/tb_clken_gen.sv
// Directed self-checking bench for clken_gen; expected pulse positions are
// hand-derived from edge numbers counted from reset release.
module tb_clken_gen;

  // Three channels so a two-bit channel select can address a non-existent
  // channel; channel 2 stays gated off and must never pulse.
  localparam int NCH      = 3;
  localparam int DIV_W    = 5;
  localparam int DIV_INIT = 14;
  localparam int CH_W     = 2;

  logic             clk14 = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [DIV_W-1:0] wr_div;
  logic [NCH-1:0]   ch_en;
  logic             pause;
  logic             step;
  logic             sync;
  logic [NCH-1:0]   clken;
  logic [NCH-1:0]   div_pending;

  int checks = 0;
  int errors = 0;
  int e      = 0;

  clken_gen #(.NCH(NCH), .DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) dut (
    .clk14       (clk14),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_div      (wr_div),
    .ch_en       (ch_en),
    .pause       (pause),
    .step        (step),
    .sync        (sync),
    .clken       (clken),
    .div_pending (div_pending)
  );

  always #5 clk14 = ~clk14;

  task automatic tick();
    @(posedge clk14);
    #1;
    e++;
  endtask

  task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] pat(input bit b1, input bit b0);
    return {1'b0, b1, b0};
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    ch_en = 3'b011; pause = 1'b0; step = 1'b0; sync = 1'b0;
    tick();
    tick();
    check("reset_clken", clken, 3'b000);
    check("reset_pending", div_pending, 3'b000);

    // Release: first pulse one cycle after the first edge without reset, then every 14.
    rst = 1'b0;
    e   = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("init_period", clken, ((k - 1) % 14 == 0) ? 3'b011 : 3'b000);
    end

    // Divisor 3 written to ch1 mid-period: current 14-cycle period completes first.
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 5'd3;
    tick();
    wr_en = 1'b0;
    check("wr_pending_set", div_pending, 3'b010);
    check("wr_no_pulse", clken, 3'b000);
    for (int k = 34; k <= 57; k++) begin
      tick();
      check("wr_pending", div_pending, (k < 42) ? 3'b010 : 3'b000);
      check("wr_period", clken, pat(k >= 43 && (k - 43) % 3 == 0, k == 43 || k == 57));
    end

    // Pause for 20 cycles with two steps; counters hold at ch0=1, ch1=0.
    for (int k = 58; k <= 77; k++) begin
      pause = 1'b1;
      step  = (k == 62 || k == 70);
      tick();
      check("pause_step", clken, (k == 62 || k == 70) ? 3'b011 : 3'b000);
    end
    pause = 1'b0; step = 1'b0;
    for (int k = 78; k <= 91; k++) begin
      tick();
      check("resume", clken, pat((k - 78) % 3 == 0, k == 91));
    end

    // Divisors 4 and 6, then sync: both coincide after sync drops, then every 12.
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 5'd4;
    tick();
    check("sync_pre_clken_a", clken, 3'b000);
    check("sync_pre_pend_a", div_pending, 3'b001);
    wr_ch = 2'd1; wr_div = 5'd6;
    tick();
    wr_en = 1'b0;
    check("sync_pre_clken_b", clken, 3'b010);
    check("sync_pre_pend_b", div_pending, 3'b011);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_clken", clken, 3'b000);
    check("sync_pending", div_pending, 3'b000);
    for (int k = 95; k <= 119; k++) begin
      tick();
      check("sync_period", clken, pat((k - 95) % 6 == 0, (k - 95) % 4 == 0));
    end

    // Divisor 1 on ch0: continuous after its wrap; divisor 0 behaves the same.
    for (int k = 120; k <= 130; k++) begin
      wr_en = (k == 120); wr_ch = 2'd0; wr_div = 5'd1;
      tick();
      check("div1_pending", div_pending, (k < 122) ? 3'b001 : 3'b000);
      check("div1_clken", clken, pat((k - 119) % 6 == 0, k >= 123));
    end
    for (int k = 131; k <= 134; k++) begin
      wr_en = (k == 131); wr_ch = 2'd0; wr_div = 5'd0;
      tick();
      check("div0_pending", div_pending, 3'b000);
      check("div0_clken", clken, pat((k - 119) % 6 == 0, 1'b1));
    end
    // Write to a channel that does not exist changes nothing.
    for (int k = 135; k <= 140; k++) begin
      wr_en = (k == 135); wr_ch = 2'd3; wr_div = 5'd7;
      tick();
      check("badch_pending", div_pending, 3'b000);
      check("badch_clken", clken, pat((k - 119) % 6 == 0, 1'b1));
    end

    // Reset mid-operation with a pending write and pause held.
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 5'd9; pause = 1'b1;
    tick();
    wr_en = 1'b0;
    check("prerst_pending", div_pending, 3'b010);
    check("prerst_clken", clken, 3'b000);
    rst = 1'b1;
    tick();
    check("midrst_clken", clken, 3'b000);
    check("midrst_pending", div_pending, 3'b000);
    rst = 1'b0; pause = 1'b0;
    for (int k = 143; k <= 157; k++) begin
      tick();
      check("postrst_period", clken, (k == 143 || k == 157) ? 3'b011 : 3'b000);
      check("postrst_pending", div_pending, 3'b000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
